// File: rtl/timeline_pkg.sv
// Shared types and helpers for the beam-timeline counter.
// sat_add is only referenced when TIMELINE_SATURATE_EN is defined.
package timeline_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 48;
    localparam int SAT_MAX_W           = 64;

    typedef logic [DEFAULT_COUNT_WIDTH-1:0] count_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SWEEP,
        SUM,
        DONE
    } state_e;

    // Returns {clamped, value}; value is clamped to 2^w-1 (w <= SAT_MAX_W).
    function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                   input logic [SAT_MAX_W-1:0] b,
                                                   input int unsigned w);
        logic [SAT_MAX_W:0] s;
        logic [SAT_MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((SAT_MAX_W+1)'(1) << w) - (SAT_MAX_W+1)'(1);
        if (s > lim) return {1'b1, lim[SAT_MAX_W-1:0]};
        return {1'b0, s[SAT_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/timeline_column_update.sv
// Combinational update of one column during a sweep: the count that stays,
// plus the beam split rightwards from column i-1 and leftwards from column i+1.
// With TIMELINE_SATURATE_EN defined, both adds clamp and clamp_o reports it.
module timeline_column_update
    import timeline_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic [COUNT_WIDTH-1:0] cnt_cur_i,
    input  logic [COUNT_WIDTH-1:0] cnt_nxt_i,
    input  logic                   split_cur_i,
    input  logic                   split_nxt_i,
    input  logic [COUNT_WIDTH-1:0] carry_i,
    output logic [COUNT_WIDTH-1:0] cnt_new_o,
    output logic [COUNT_WIDTH-1:0] carry_o
`ifdef TIMELINE_SATURATE_EN
    ,
    output logic                   clamp_o
`endif
);

    logic [COUNT_WIDTH-1:0] stay;
    logic [COUNT_WIDTH-1:0] from_right;

    assign stay       = split_cur_i ? '0 : cnt_cur_i;
    assign from_right = split_nxt_i ? cnt_nxt_i : '0;
    assign carry_o    = split_cur_i ? cnt_cur_i : '0;

`ifdef TIMELINE_SATURATE_EN
    logic [SAT_MAX_W:0] s1;
    logic [SAT_MAX_W:0] s2;

    always_comb begin
        s1 = sat_add(SAT_MAX_W'(stay), SAT_MAX_W'(carry_i), COUNT_WIDTH);
        s2 = sat_add(SAT_MAX_W'(s1), SAT_MAX_W'(from_right), COUNT_WIDTH);
    end

    assign cnt_new_o = COUNT_WIDTH'(s2);
    assign clamp_o   = s1[SAT_MAX_W] | s2[SAT_MAX_W];
`else
    assign cnt_new_o = stay + carry_i + from_right;
`endif

endmodule

// File: rtl/timeline_counter.sv
// Counts distinct beam timelines per column across splitter lines, then sums
// them after end of file. Optional macro TIMELINE_SATURATE_EN: saturating adds.
module timeline_counter
    import timeline_pkg::*;
#(
    parameter int LINE_WIDTH  = 160,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   test_logic_reset,
    input  logic                   line_valid,
    input  logic [LINE_WIDTH-1:0]  line_data,
    input  logic                   end_of_file,
    output logic                   result_valid,
    output logic [COUNT_WIDTH-1:0] result_data,
    output logic                   overflow
`ifdef TIMELINE_SATURATE_EN
    ,
    output logic                   saturated
`endif
);

    localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int IW = $clog2(LINE_WIDTH + 1);

    state_e                                   state_q, state_d;
    logic [LINE_WIDTH-1:0][COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0]                    split_q, split_d;
    logic [IW-1:0]                            idx_q, idx_d;
    logic [COUNT_WIDTH-1:0]                   carry_q, carry_d;
    logic [COUNT_WIDTH-1:0]                   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]                   result_q, result_d;
    logic                                     rvalid_q, rvalid_d;
    logic                                     ovf_q, ovf_d;
    logic                                     eofp_q, eofp_d;

    logic [AW-1:0]          col, nxt_col;
    logic                   last_col;
    logic [COUNT_WIDTH-1:0] cnt_cur, cnt_nxt, cnt_new, carry_new, acc_next;
    logic                   split_nxt;

    // The sum phase runs idx one past the last column; col is only used while idx < LINE_WIDTH.
    assign col       = AW'(idx_q);
    assign last_col  = (idx_q == IW'(LINE_WIDTH - 1));
    assign nxt_col   = last_col ? col : col + AW'(1);
    assign cnt_cur   = cnt_q[col];
    assign cnt_nxt   = cnt_q[nxt_col];
    assign split_nxt = last_col ? 1'b0 : split_q[nxt_col];

`ifdef TIMELINE_SATURATE_EN
    logic               col_clamp, sum_clamp;
    logic               sat_q, sat_d;
    logic [SAT_MAX_W:0] sum_s;

    always_comb begin
        sum_s = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(cnt_cur), COUNT_WIDTH);
    end
    assign acc_next  = COUNT_WIDTH'(sum_s);
    assign sum_clamp = sum_s[SAT_MAX_W];
    assign saturated = sat_q;
`else
    assign acc_next = acc_q + cnt_cur;
`endif

    timeline_column_update #(.COUNT_WIDTH(COUNT_WIDTH)) u_col (
        .cnt_cur_i  (cnt_cur),
        .cnt_nxt_i  (cnt_nxt),
        .split_cur_i(split_q[col]),
        .split_nxt_i(split_nxt),
        .carry_i    (carry_q),
        .cnt_new_o  (cnt_new),
        .carry_o    (carry_new)
`ifdef TIMELINE_SATURATE_EN
        ,
        .clamp_o    (col_clamp)
`endif
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        split_d  = split_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        eofp_d   = eofp_q;
`ifdef TIMELINE_SATURATE_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            INIT: begin
                if (line_valid) begin
                    for (int c = 0; c < LINE_WIDTH; c++) cnt_d[c] = COUNT_WIDTH'(line_data[c]);
                    state_d = IDLE;
                end
                if (end_of_file) begin
                    state_d = SUM;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            IDLE: begin
                if (line_valid) begin
                    split_d = line_data;
                    idx_d   = '0;
                    carry_d = '0;
                    eofp_d  = end_of_file;
                    state_d = SWEEP;
                end else if (end_of_file) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SUM;
                end
            end
            SWEEP: begin
                cnt_d[col] = cnt_new;
                carry_d    = carry_new;
`ifdef TIMELINE_SATURATE_EN
                sat_d      = sat_q | col_clamp;
`endif
                if (line_valid) ovf_d = 1'b1;
                if (end_of_file) eofp_d = 1'b1;
                if (last_col) begin
                    if (eofp_q || end_of_file) begin
                        eofp_d  = 1'b0;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = SUM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SUM: begin
                if (line_valid) ovf_d = 1'b1;
                if (idx_q == IW'(LINE_WIDTH)) begin
                    result_d = acc_q;
                    rvalid_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d = acc_next;
                    idx_d = idx_q + IW'(1);
`ifdef TIMELINE_SATURATE_EN
                    sat_d = sat_q | sum_clamp;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (test_logic_reset) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            split_q  <= '0;
            idx_q    <= '0;
            carry_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            eofp_q   <= 1'b0;
`ifdef TIMELINE_SATURATE_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            split_q  <= split_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            eofp_q   <= eofp_d;
`ifdef TIMELINE_SATURATE_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign result_valid = rvalid_q;
    assign result_data  = result_q;
    assign overflow     = ovf_q;

endmodule
